// File: rtl/vga2_issuer_pkg.sv
// Shared VGA2 definitions: instruction opcodes and issuer FSM state encoding.
package vga2_issuer_pkg;

  localparam logic [3:0] VGA2_NOP = 4'd0;
  localparam logic [3:0] VGA2_LDR = 4'd1;
  localparam logic [3:0] VGA2_LDC = 4'd2;
  localparam logic [3:0] VGA2_LDD = 4'd3;
  localparam logic [3:0] VGA2_LDI = 4'd4;

  typedef enum logic [2:0] {
    StIdle,
    StRow,
    StCol,
    StData,
    StGap
  } state_e;

  // Pack an opcode and immediate into a 12-bit VGA2 instruction word.
  function automatic logic [11:0] vga2_inst(logic [3:0] op, logic [7:0] imm);
    return {op, imm};
  endfunction

endpackage

// File: rtl/vga2_issuer_plan.sv
// Request planner: compares a pixel request against the shadow of VGA2's
// row/col registers and decides which load instructions are required.
module vga2_issuer_plan #(
  parameter int unsigned Rows = 150,
  parameter int unsigned Cols = 200
) (
  input  logic [7:0] row,
  input  logic [7:0] col,
  input  logic       shadow_valid,
  input  logic [7:0] shadow_row,
  input  logic [7:0] shadow_col,
  output logic       need_row,
  output logic       need_col,
  output logic       use_ldi,
  output logic       out_of_range
);

  localparam logic [8:0] RowsLim = 9'(Rows);
  localparam logic [8:0] ColsLim = 9'(Cols);

  logic       same_row;
  logic       same_col;
  logic [7:0] next_col;

  // Pure combinational comparison against the shadow registers.
  always_comb begin
    next_col     = shadow_col + 8'd1;  // VGA2 LDI wraps 255 -> 0
    same_row     = shadow_valid && (row == shadow_row);
    same_col     = shadow_valid && (col == shadow_col);
    out_of_range = ({1'b0, row} >= RowsLim) || ({1'b0, col} >= ColsLim);
    use_ldi      = same_row && (col == next_col);
    need_row     = !same_row;
    need_col     = !same_col && !use_ldi;
  end

endmodule

// File: rtl/vga2_issuer.sv
// VGA2 instruction issuer: turns pixel-write requests into the shortest
// LDR/LDC/LDD/LDI sequence, tracking VGA2's row/col registers in a shadow.
module vga2_issuer
  import vga2_issuer_pkg::*;
#(
  parameter int unsigned Rows     = 150,
  parameter int unsigned Cols     = 200,
  parameter int unsigned IssueGap = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_row,
  input  logic [7:0]  req_col,
  input  logic [3:0]  req_color,
  input  logic        resync,
  output logic [11:0] inst,
  output logic        inst_en,
  output logic        err
);

  localparam logic [3:0] GapLast = 4'(IssueGap - 1);

  state_e      state_q, state_d, ret_q, ret_d, after, go_st;
  logic [3:0]  gap_q, gap_d;
  logic        sh_valid_q, sh_valid_d;
  logic [7:0]  sh_row_q, sh_row_d, sh_col_q, sh_col_d;
  logic [7:0]  row_q, row_d, col_q, col_d;
  logic [3:0]  color_q, color_d;
  logic        need_col_q, need_col_d, use_ldi_q, use_ldi_d;
  logic [11:0] inst_q, inst_d;
  logic        inst_en_q, inst_en_d, err_q, err_d;
  logic        go;
  logic        plan_need_row, plan_need_col, plan_use_ldi, plan_oor;

  vga2_issuer_plan #(
    .Rows (Rows),
    .Cols (Cols)
  ) u_plan (
    .row          (req_row),
    .col          (req_col),
    .shadow_valid (sh_valid_q),
    .shadow_row   (sh_row_q),
    .shadow_col   (sh_col_q),
    .need_row     (plan_need_row),
    .need_col     (plan_need_col),
    .use_ldi      (plan_use_ldi),
    .out_of_range (plan_oor)
  );

  assign req_ready = (state_q == StIdle) && !resync;
  assign inst      = inst_q;
  assign inst_en   = inst_en_q;
  assign err       = err_q;

  // Planned successor of the issue state currently being output.
  always_comb begin
    case (state_q)
      StRow:   after = need_col_q ? StCol : StData;
      StCol:   after = StData;
      default: after = StIdle;
    endcase
  end

  // Next-state logic; instructions are registered on entry to an issue state.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    gap_d      = gap_q;
    sh_valid_d = sh_valid_q;
    sh_row_d   = sh_row_q;
    sh_col_d   = sh_col_q;
    row_d      = row_q;
    col_d      = col_q;
    color_d    = color_q;
    need_col_d = need_col_q;
    use_ldi_d  = use_ldi_q;
    inst_d     = inst_q;
    inst_en_d  = 1'b0;
    err_d      = 1'b0;
    go         = 1'b0;
    go_st      = StIdle;

    case (state_q)
      StIdle: begin
        if (resync) begin
          sh_valid_d = 1'b0;
        end else if (req_valid) begin
          if (plan_oor) begin
            err_d = 1'b1;
          end else begin
            row_d      = req_row;
            col_d      = req_col;
            color_d    = req_color;
            need_col_d = plan_need_col;
            use_ldi_d  = plan_use_ldi;
            go         = 1'b1;
            go_st      = plan_need_row ? StRow : (plan_need_col ? StCol : StData);
          end
        end
      end
      StRow, StCol, StData: begin
        if (IssueGap != 0) begin
          state_d = StGap;
          ret_d   = after;
          gap_d   = GapLast;
        end else if (after == StIdle) begin
          state_d = StIdle;
        end else begin
          go    = 1'b1;
          go_st = after;
        end
      end
      StGap: begin
        if (gap_q == 4'd0) begin
          if (ret_q == StIdle) begin
            state_d = StIdle;
          end else begin
            go    = 1'b1;
            go_st = ret_q;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d    = StIdle;
        sh_valid_d = 1'b0;
      end
    endcase

    // Issue one instruction and apply its effect to the shadow.
    if (go) begin
      state_d   = go_st;
      inst_en_d = 1'b1;
      case (go_st)
        StRow: begin
          inst_d   = vga2_inst(VGA2_LDR, row_d);
          sh_row_d = row_d;
        end
        StCol: begin
          inst_d   = vga2_inst(VGA2_LDC, col_d);
          sh_col_d = col_d;
        end
        default: begin
          inst_d     = vga2_inst(use_ldi_d ? VGA2_LDI : VGA2_LDD, {4'h0, color_d});
          sh_valid_d = 1'b1;
          if (use_ldi_d) sh_col_d = sh_col_q + 8'd1;
        end
      endcase
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ret_q      <= StIdle;
      gap_q      <= 4'd0;
      sh_valid_q <= 1'b0;
      sh_row_q   <= 8'd0;
      sh_col_q   <= 8'd0;
      row_q      <= 8'd0;
      col_q      <= 8'd0;
      color_q    <= 4'd0;
      need_col_q <= 1'b0;
      use_ldi_q  <= 1'b0;
      inst_q     <= {VGA2_NOP, 8'd0};
      inst_en_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      gap_q      <= gap_d;
      sh_valid_q <= sh_valid_d;
      sh_row_q   <= sh_row_d;
      sh_col_q   <= sh_col_d;
      row_q      <= row_d;
      col_q      <= col_d;
      color_q    <= color_d;
      need_col_q <= need_col_d;
      use_ldi_q  <= use_ldi_d;
      inst_q     <= inst_d;
      inst_en_q  <= inst_en_d;
      err_q      <= err_d;
    end
  end

endmodule
